// File: rtl/irq_ctrl_if.sv
// irq_ctrl_if: request/acknowledge register bus between a master and irq_ctrl
// Signals: i_REQ, i_WE, i_ADDR, i_WDATA driven by the master; o_RDATA, o_ACK driven by the slave
interface irq_ctrl_if;
  logic        i_REQ;
  logic        i_WE;
  logic [3:0]  i_ADDR;
  logic [31:0] i_WDATA;
  logic [31:0] o_RDATA;
  logic        o_ACK;
  modport master(output i_REQ, i_WE, i_ADDR, i_WDATA, input o_RDATA, o_ACK);
  modport slave(input i_REQ, i_WE, i_ADDR, i_WDATA, output o_RDATA, o_ACK);
endinterface

// File: rtl/irq_ctrl.sv
// irq_ctrl: 6-source interrupt controller with synchronizers, edge/level pending and claim/complete
// Ports: i_CLK clock; i_RSTn async active-low reset; i_IRQ_SRC async sources;
//        bus slave (PENDING 0x0, MODE 0x4, CLAIM 0x8, COMPLETE 0xC); o_MEI per-source interrupt lines
module irq_ctrl #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       i_CLK,
  input  logic       i_RSTn,
  input  logic [5:0] i_IRQ_SRC,
  irq_ctrl_if.slave  bus,
  output logic [5:0] o_MEI
);
  typedef enum logic {IDLE, ACK} state_t;
  state_t state_q, state_d;
  logic [SYNC_STAGES-1:0][5:0] sync_q;
  logic [5:0] s_d_q, pending_q, pending_d, inserv_q, inserv_d, mode_q, mode_d;
  logic [5:0] s, rise, elig, claim, w1c, cmp;
  logic [31:0] rdata_q, rdata_d;
  logic [2:0] id;
  logic [1:0] sel;
  logic acc, rd, wr, unused_bits;
  assign unused_bits = ^{bus.i_ADDR[1:0], bus.i_WDATA[31:6]};
  assign s = sync_q[SYNC_STAGES-1];
  assign rise = s & ~s_d_q;
  assign elig = pending_q & ~inserv_q;
  assign o_MEI = elig;
  assign sel = bus.i_ADDR[3:2];
  assign acc = (state_q == IDLE) && bus.i_REQ;
  assign rd = acc && !bus.i_WE;
  assign wr = acc && bus.i_WE;
  assign bus.o_ACK = state_q == ACK;
  assign bus.o_RDATA = (state_q == ACK) ? rdata_q : '0;
  always_comb begin
    id = 3'd0;
    for (int i = 5; i >= 0; i--) if (elig[i]) id = 3'(i + 1);
    cmp = '0;
    for (int i = 0; i < 6; i++) cmp[i] = wr && sel == 2'd3 && bus.i_WDATA[2:0] == 3'(i + 1);
  end
  // claim isolates the lowest eligible bit; a set event in edge mode beats any clear
  always_comb begin
    claim = (rd && sel == 2'd2) ? elig & (~elig + 6'd1) : '0;
    w1c = (wr && sel == 2'd0) ? bus.i_WDATA[5:0] : '0;
    pending_d = (mode_q & (rise | (pending_q & ~(w1c | claim)))) | (~mode_q & s);
    inserv_d = (inserv_q | claim) & ~cmp;
    mode_d = (wr && sel == 2'd1) ? bus.i_WDATA[5:0] : mode_q;
    rdata_d = !rd ? '0 :
              sel == 2'd0 ? {26'b0, pending_q} :
              sel == 2'd1 ? {26'b0, mode_q} :
              sel == 2'd2 ? {29'b0, id} : '0;
    state_d = (state_q == IDLE && bus.i_REQ) ? ACK : IDLE;
  end
  always_ff @(posedge i_CLK or negedge i_RSTn)
    if (!i_RSTn) begin
      sync_q <= '0;
      s_d_q <= '0;
      pending_q <= '0;
      inserv_q <= '0;
      mode_q <= '0;
      rdata_q <= '0;
      state_q <= IDLE;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], i_IRQ_SRC};
      s_d_q <= s;
      pending_q <= pending_d;
      inserv_q <= inserv_d;
      mode_q <= mode_d;
      rdata_q <= rdata_d;
      state_q <= state_d;
    end
endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: randomized and directed self-checking bench for irq_ctrl against a behavioural model
module tb_irq_ctrl;
  logic i_CLK = 0, i_RSTn = 0;
  logic [5:0] i_IRQ_SRC, o_MEI;
  int checks = 0, errors = 0;
  irq_ctrl_if bus();
  irq_ctrl #(.SYNC_STAGES(2)) dut (.i_CLK(i_CLK), .i_RSTn(i_RSTn), .i_IRQ_SRC(i_IRQ_SRC), .bus(bus), .o_MEI(o_MEI));
  always #5 i_CLK = ~i_CLK;
  typedef struct packed {
    logic [5:0] pend, ins, mode;
    logic busy;
    logic [31:0] rd;
  } mst_t;
  mst_t m;
  logic [5:0] smp1, smp2, smp3;
  function automatic mst_t step(mst_t c, logic [5:0] s, logic [5:0] sd, logic req, logic we, logic [3:0] a, logic [31:0] wd);
    mst_t n = c;
    logic [5:0] el = c.pend & ~c.ins;
    int id = 0;
    bit acc = req && !c.busy;
    for (int i = 5; i >= 0; i--) if (el[i]) id = i + 1;
    n.busy = acc;
    n.rd = 0;
    for (int i = 0; i < 6; i++)
      if (!c.mode[i]) n.pend[i] = s[i];
      else if (s[i] && !sd[i]) n.pend[i] = 1;
      else if (acc && we && a[3:2] == 0 && wd[i]) n.pend[i] = 0;
      else if (acc && !we && a[3:2] == 2 && id == i + 1) n.pend[i] = 0;
    if (acc && !we)
      case (a[3:2])
        0: n.rd = {26'b0, c.pend};
        1: n.rd = {26'b0, c.mode};
        2: n.rd = 32'(id);
        default: n.rd = 0;
      endcase
    if (acc && !we && a[3:2] == 2 && id != 0) n.ins[id-1] = 1;
    if (acc && we && a[3:2] == 3 && wd[2:0] >= 1 && wd[2:0] <= 6) n.ins[wd[2:0]-1] = 0;
    if (acc && we && a[3:2] == 1) n.mode = wd[5:0];
    return n;
  endfunction
  // a source sample taken at edge e is seen by the pending logic at edge e+2
  always @(posedge i_CLK or negedge i_RSTn)
    if (!i_RSTn) begin
      m <= '0;
      smp1 <= 0;
      smp2 <= 0;
      smp3 <= 0;
    end else begin
      m <= step(m, smp2, smp3, bus.i_REQ, bus.i_WE, bus.i_ADDR, bus.i_WDATA);
      smp1 <= i_IRQ_SRC;
      smp2 <= smp1;
      smp3 <= smp2;
    end
  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge i_CLK);
      #1;
    end
  endtask
  task automatic xfer(input logic we, input logic [3:0] a, input logic [31:0] wd, output logic ack, output logic [31:0] rd);
    bus.i_REQ = 1;
    bus.i_WE = we;
    bus.i_ADDR = a;
    bus.i_WDATA = wd;
    cycles(1);
    ack = bus.o_ACK;
    rd = bus.o_RDATA;
    bus.i_REQ = 0;
    bus.i_WE = 0;
    bus.i_WDATA = 0;
    cycles(1);
  endtask
  task automatic test_reset;
    logic ack;
    logic [31:0] rd;
    cycles(3);
    checks++;
    if (o_MEI !== 0 || bus.o_ACK !== 0 || bus.o_RDATA !== 0) begin
      errors++;
      $display("FAIL reset_outputs mei=%h ack=%b rdata=%h required 0/0/0", o_MEI, bus.o_ACK, bus.o_RDATA);
    end
    i_RSTn = 1;
    cycles(1);
    xfer(0, 4'h4, 0, ack, rd);
    checks++;
    if (ack !== 1 || rd !== 0) begin
      errors++;
      $display("FAIL reset_mode ack=%b rdata=%h required 1/0", ack, rd);
    end
    xfer(0, 4'h0, 0, ack, rd);
    checks++;
    if (rd !== 0) begin
      errors++;
      $display("FAIL reset_pending rdata=%h required 0", rd);
    end
  endtask
  task automatic test_level;
    logic ack;
    logic [31:0] rd;
    logic [5:0] exp_m [6] = '{6'h00, 6'h00, 6'h04, 6'h04, 6'h04, 6'h00};
    i_IRQ_SRC = 6'h04;
    for (int c = 0; c < 6; c++) begin
      cycles(1);
      if (c == 2) i_IRQ_SRC = 0;
      checks++;
      if (o_MEI !== exp_m[c]) begin
        errors++;
        $display("FAIL level_latency cycle %0d mei=%h required %h", c, o_MEI, exp_m[c]);
      end
    end
    i_IRQ_SRC = 6'h20;
    cycles(3);
    xfer(1, 4'h0, 32'h20, ack, rd);
    xfer(0, 4'h0, 0, ack, rd);
    checks++;
    if (rd !== 32'h20) begin
      errors++;
      $display("FAIL level_w1c rdata=%h required 20", rd);
    end
    i_IRQ_SRC = 0;
    cycles(3);
  endtask
  task automatic test_edge_w1c;
    logic ack;
    logic [31:0] rd;
    xfer(1, 4'h4, 32'h3F, ack, rd);
    xfer(0, 4'h4, 0, ack, rd);
    checks++;
    if (rd !== 32'h3F) begin
      errors++;
      $display("FAIL edge_mode_rd rdata=%h required 3f", rd);
    end
    i_IRQ_SRC = 6'h01;
    cycles(1);
    i_IRQ_SRC = 0;
    cycles(3);
    xfer(0, 4'h0, 0, ack, rd);
    checks++;
    if (rd !== 32'h1) begin
      errors++;
      $display("FAIL edge_pending rdata=%h required 1", rd);
    end
    xfer(1, 4'h0, 32'h1, ack, rd);
    xfer(0, 4'h0, 0, ack, rd);
    checks++;
    if (rd !== 0 || o_MEI !== 0) begin
      errors++;
      $display("FAIL edge_w1c rdata=%h mei=%h required 0/0", rd, o_MEI);
    end
  endtask
  task automatic test_claim;
    logic ack;
    logic [31:0] rd;
    logic [31:0] ids [3] = '{32'd2, 32'd5, 32'd0};
    i_IRQ_SRC = 6'h12;
    cycles(1);
    i_IRQ_SRC = 0;
    cycles(3);
    checks++;
    if (o_MEI !== 6'h12) begin
      errors++;
      $display("FAIL claim_setup mei=%h required 12", o_MEI);
    end
    for (int k = 0; k < 3; k++) begin
      xfer(0, 4'h8, 0, ack, rd);
      checks++;
      if (rd !== ids[k]) begin
        errors++;
        $display("FAIL claim_id %0d rdata=%0d required %0d", k, rd, ids[k]);
      end
    end
    checks++;
    if (o_MEI !== 0) begin
      errors++;
      $display("FAIL claim_mei mei=%h required 0", o_MEI);
    end
    xfer(1, 4'hC, 32'd2, ack, rd);
    i_IRQ_SRC = 6'h12;
    cycles(1);
    i_IRQ_SRC = 0;
    cycles(3);
    checks++;
    if (o_MEI !== 6'h02) begin
      errors++;
      $display("FAIL complete2 mei=%h required 02", o_MEI);
    end
    xfer(1, 4'hC, 32'd5, ack, rd);
    checks++;
    if (o_MEI !== 6'h12) begin
      errors++;
      $display("FAIL complete5 mei=%h required 12", o_MEI);
    end
    xfer(1, 4'h0, 32'h12, ack, rd);
  endtask
  task automatic test_collision;
    logic ack;
    logic [31:0] rd;
    i_IRQ_SRC = 6'h08;
    cycles(2);
    xfer(1, 4'h0, 32'h08, ack, rd);
    xfer(0, 4'h0, 0, ack, rd);
    checks++;
    if (rd !== 32'h08 || o_MEI !== 6'h08) begin
      errors++;
      $display("FAIL collision rdata=%h mei=%h required 08/08", rd, o_MEI);
    end
    i_IRQ_SRC = 0;
    xfer(1, 4'h0, 32'h08, ack, rd);
    xfer(0, 4'h0, 0, ack, rd);
    checks++;
    if (rd !== 0) begin
      errors++;
      $display("FAIL collision_clear rdata=%h required 0", rd);
    end
  endtask
  task automatic test_back_to_back;
    logic ack;
    logic [31:0] rd;
    logic ea [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    bus.i_REQ = 1;
    bus.i_WE = 0;
    bus.i_ADDR = 4'h4;
    for (int c = 0; c < 4; c++) begin
      cycles(1);
      if (c == 2) bus.i_REQ = 0;
      checks++;
      if (bus.o_ACK !== ea[c] || bus.o_RDATA !== (ea[c] ? 32'h3F : 32'h0)) begin
        errors++;
        $display("FAIL b2b cycle %0d ack=%b rdata=%h required %b", c, bus.o_ACK, bus.o_RDATA, ea[c]);
      end
    end
    xfer(1, 4'h4, 32'h3E, ack, rd);
    i_IRQ_SRC = 6'h01;
    cycles(3);
    xfer(0, 4'h8, 0, ack, rd);
    checks++;
    if (rd !== 1 || o_MEI !== 0) begin
      errors++;
      $display("FAIL level_claim rdata=%h mei=%h required 1/0", rd, o_MEI);
    end
    xfer(1, 4'hC, 32'd7, ack, rd);
    xfer(1, 4'hC, 32'd0, ack, rd);
    xfer(1, 4'h8, 32'd1, ack, rd);
    xfer(0, 4'hC, 0, ack, rd);
    checks++;
    if (rd !== 0 || o_MEI !== 0) begin
      errors++;
      $display("FAIL complete_ignored rdata=%h mei=%h required 0/0", rd, o_MEI);
    end
    xfer(1, 4'hC, 32'd1, ack, rd);
    xfer(0, 4'h5, 0, ack, rd);
    checks++;
    if (rd !== 32'h3E || o_MEI !== 6'h01) begin
      errors++;
      $display("FAIL complete1_alias rdata=%h mei=%h required 3e/01", rd, o_MEI);
    end
    i_IRQ_SRC = 0;
    cycles(3);
  endtask
  task automatic test_reset_mid;
    logic ack;
    logic [31:0] rd;
    xfer(1, 4'h4, 32'h15, ack, rd);
    i_IRQ_SRC = 6'h3F;
    cycles(3);
    checks++;
    if (o_MEI !== 6'h3F) begin
      errors++;
      $display("FAIL mid_setup mei=%h required 3f", o_MEI);
    end
    bus.i_REQ = 1;
    bus.i_WE = 0;
    bus.i_ADDR = 4'h4;
    cycles(1);
    i_RSTn = 0;
    #1;
    checks++;
    if (bus.o_ACK !== 0 || o_MEI !== 0 || bus.o_RDATA !== 0) begin
      errors++;
      $display("FAIL mid_reset ack=%b mei=%h rdata=%h required 0/0/0", bus.o_ACK, o_MEI, bus.o_RDATA);
    end
    bus.i_REQ = 0;
    @(posedge i_CLK);
    #1;
    i_RSTn = 1;
    xfer(0, 4'h4, 0, ack, rd);
    checks++;
    if (rd !== 0) begin
      errors++;
      $display("FAIL mid_mode rdata=%h required 0", rd);
    end
    i_IRQ_SRC = 0;
    cycles(3);
  endtask
  task automatic test_random;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) == 0) i_IRQ_SRC = 6'($urandom);
      bus.i_REQ = 1'($urandom);
      bus.i_WE = 1'($urandom);
      bus.i_ADDR = 4'($urandom);
      bus.i_WDATA = (bus.i_ADDR[3:2] == 2'd3) ? 32'($urandom_range(0, 7)) : $urandom;
      cycles(1);
      checks++;
      if (o_MEI !== (m.pend & ~m.ins) || bus.o_ACK !== m.busy || bus.o_RDATA !== (m.busy ? m.rd : 32'h0)) begin
        errors++;
        $display("FAIL random cycle %0d mei=%h ack=%b rdata=%h required %h/%b/%h", c, o_MEI, bus.o_ACK,
                 bus.o_RDATA, m.pend & ~m.ins, m.busy, m.busy ? m.rd : 32'h0);
      end
    end
    bus.i_REQ = 0;
    i_IRQ_SRC = 0;
  endtask
  initial begin
    i_IRQ_SRC = 0;
    bus.i_REQ = 0;
    bus.i_WE = 0;
    bus.i_ADDR = 0;
    bus.i_WDATA = 0;
    test_reset;
    test_level;
    test_edge_w1c;
    test_claim;
    test_collision;
    test_back_to_back;
    test_reset_mid;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
